// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared types and helpers for the multi-port register file
//   rf_state_e : clear sequencer states
//   ZERO_ADDR  : index of the optional hard-wired zero register
//   rf_aw(n)   : address width needed to index n registers
package regfile_mp_pkg;
    typedef enum logic {CLEAR, RUN} rf_state_e;
    localparam int ZERO_ADDR = 0;
    function automatic int rf_aw(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: register file access bundle
//   ready     : clear done, ports live
//   wr_en/wr_addr/wr_data : per-port write request, port p at [p*AW +: AW] / [p*XLEN +: XLEN]
//   rd_en/rd_addr/rd_data : per-port read request and registered read data
//   debug_reg : flattened live array contents, reg i at [i*XLEN +: XLEN]
interface regfile_mp_if
    import regfile_mp_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1
);
    localparam int AW = rf_aw(NREGS);
    logic                  ready;
    logic [NWR-1:0]        wr_en;
    logic [NWR*AW-1:0]     wr_addr;
    logic [NWR*XLEN-1:0]   wr_data;
    logic [NRD-1:0]        rd_en;
    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*XLEN-1:0]   rd_data;
    logic [NREGS*XLEN-1:0] debug_reg;
    modport master (input ready, rd_data, debug_reg, output wr_en, wr_addr, wr_data, rd_en, rd_addr);
    modport slave (output ready, rd_data, debug_reg, input wr_en, wr_addr, wr_data, rd_en, rd_addr);
endinterface

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: after reset, zeroes one register per cycle, then declares the file ready
//   clk, rst : clock and synchronous active-high reset
//   clr_we   : clear write strobe (high throughout CLEAR)
//   clr_addr : entry being cleared this cycle
//   ready    : high from the first RUN cycle on
module regfile_clr_seq
    import regfile_mp_pkg::*;
#(
    parameter int NREGS = 32,
    localparam int AW = rf_aw(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          ready
);
    rf_state_e state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            clr_we   <= 1'b1;
            ready    <= 1'b0;
        end else if (state == CLEAR) begin
            clr_addr <= clr_addr + AW'(1);
            if (clr_addr == AW'(NREGS - 1)) begin
                state  <= RUN;
                clr_we <= 1'b0;
                ready  <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with prioritised writes and write-first registered reads
//   clk, rst : clock and synchronous active-high reset
//   bus      : regfile_mp_if slave (ready, wr_*, rd_*, debug_reg)
//   ZERO_REG : 1 makes register 0 read as zero and ignore writes
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter bit ZERO_REG = 1'b1
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    localparam int AW = rf_aw(NREGS);

    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic            ready;
    logic [XLEN-1:0] mem [NREGS];
    logic [NREGS-1:0] wr_hit;
    logic [XLEN-1:0] wr_val [NREGS];

    regfile_clr_seq #(.NREGS(NREGS)) u_clr (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    assign bus.ready = ready;

    // ports are scanned in ascending order so a later port overwrites an earlier one on the same entry
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NREGS; i++) wr_val[i] = '0;
        for (int p = 0; p < NWR; p++)
            if (ready && bus.wr_en[p]) begin
                wr_hit[bus.wr_addr[p*AW +: AW]] = 1'b1;
                wr_val[bus.wr_addr[p*AW +: AW]] = bus.wr_data[p*XLEN +: XLEN];
            end
        if (ZERO_REG) wr_hit[ZERO_ADDR] = 1'b0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++)
            if (clr_we && clr_addr == AW'(i)) mem[i] <= '0;
            else if (wr_hit[i]) mem[i] <= wr_val[i];
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_dbg
        assign bus.debug_reg[i*XLEN +: XLEN] = (ZERO_REG && i == ZERO_ADDR) ? '0 : mem[i];
    end

    for (genvar q = 0; q < NRD; q++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd_nxt;
        logic [XLEN-1:0] rd_q;
        assign ra = bus.rd_addr[q*AW +: AW];
        // write-first: a same-cycle write to the read address is forwarded instead of the stale entry
        assign rd_nxt = (ZERO_REG && ra == AW'(ZERO_ADDR)) ? '0 : wr_hit[ra] ? wr_val[ra] : mem[ra];
        always_ff @(posedge clk) begin
            if (rst || !ready) rd_q <= '0;
            else if (bus.rd_en[q]) rd_q <= rd_nxt;
        end
        assign bus.rd_data[q*XLEN +: XLEN] = rd_q;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench driving a zero-register and a plain instance with identical stimulus
module tb_regfile_mp;
    import regfile_mp_pkg::*;
    localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

    typedef struct {
        int              due;
        int              d;
        logic            rdy;
        logic [XLEN-1:0] rd [NRD];
        logic            chk_dbg;
        logic [XLEN-1:0] dbg [NREGS];
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) ia ();
    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) ib ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1'b1)) dut_a (
        .clk (clk), .rst (rst), .bus (ia.slave));
    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1'b0)) dut_b (
        .clk (clk), .rst (rst), .bus (ib.slave));

    assign ib.wr_en   = ia.wr_en;
    assign ib.wr_addr = ia.wr_addr;
    assign ib.wr_data = ia.wr_data;
    assign ib.rd_en   = ia.rd_en;
    assign ib.rd_addr = ia.rd_addr;

    exp_t sbq[$];
    int cyc = 0, n_chk = 0, n_fail = 0;
    int cnt = 0;
    logic [XLEN-1:0] mem [2][NREGS];
    logic [XLEN-1:0] last [2][NRD];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            chk("sb_due", cyc, e.due);
            chk($sformatf("d%0d_ready", e.d), e.d != 0 ? ib.ready : ia.ready, e.rdy);
            for (int q = 0; q < NRD; q++)
                chk($sformatf("d%0d_rd%0d", e.d, q),
                    e.d != 0 ? ib.rd_data[q*XLEN +: XLEN] : ia.rd_data[q*XLEN +: XLEN], e.rd[q]);
            if (e.chk_dbg)
                for (int i = 0; i < NREGS; i++)
                    chk($sformatf("d%0d_dbg%0d", e.d, i),
                        e.d != 0 ? ib.debug_reg[i*XLEN +: XLEN] : ia.debug_reg[i*XLEN +: XLEN], e.dbg[i]);
        end
    end

    // reference model: instance 0 has the zero register, instance 1 does not
    task automatic cycle();
        exp_t e;
        logic [XLEN-1:0] nm [NREGS];
        int ncnt;
        bit rp;
        rp = cnt >= NREGS;
        ncnt = rst ? 0 : (cnt < NREGS ? cnt + 1 : cnt);
        for (int d = 0; d < 2; d++) begin
            nm = mem[d];
            if (rp)
                for (int p = 0; p < NWR; p++) begin
                    int a;
                    a = int'(ia.wr_addr[p*AW +: AW]);
                    if (ia.wr_en[p] && !(d == 0 && a == 0)) nm[a] = ia.wr_data[p*XLEN +: XLEN];
                end
            if (!rst && !rp) nm[cnt] = '0;
            e.due = cyc + 1;
            e.d = d;
            e.rdy = ncnt >= NREGS;
            for (int q = 0; q < NRD; q++) begin
                int a;
                a = int'(ia.rd_addr[q*AW +: AW]);
                e.rd[q] = (rst || !rp) ? '0 : !ia.rd_en[q] ? last[d][q] : (d == 0 && a == 0) ? '0 : nm[a];
            end
            e.chk_dbg = e.rdy;
            e.dbg = nm;
            sbq.push_back(e);
            mem[d] = nm;
            last[d] = e.rd;
        end
        cnt = ncnt;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [1:0] we, int a0, int a1, logic [XLEN-1:0] d0, logic [XLEN-1:0] d1,
                         logic [1:0] re, int r0, int r1);
        ia.wr_en = we;
        ia.wr_addr = {AW'(a1), AW'(a0)};
        ia.wr_data = {d1, d0};
        ia.rd_en = re;
        ia.rd_addr = {AW'(r1), AW'(r0)};
        cycle();
    endtask

    task automatic idle(int n);
        repeat (n) drive(2'b00, 0, 0, '0, '0, 2'b00, 0, 0);
    endtask

    initial begin
        ia.wr_en = '0; ia.wr_addr = '0; ia.wr_data = '0; ia.rd_en = '0; ia.rd_addr = '0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        repeat (NREGS) drive(2'b00, 0, 0, '0, '0, 2'b11, 5, 5);
        drive(2'b00, 0, 0, '0, '0, 2'b11, 5, 5);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(10);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(5);
        drive(2'b01, 2, 0, 32'h0BAD, '0, 2'b01, 2, 0);
        idle(NREGS - 6);
        drive(2'b00, 0, 0, '0, '0, 2'b11, 2, 2);
        drive(2'b11, 7, 7, 32'h11, 32'h22, 2'b00, 0, 0);
        drive(2'b00, 0, 0, '0, '0, 2'b01, 7, 0);
        drive(2'b01, 3, 0, 32'hAAAA, '0, 2'b00, 0, 0);
        drive(2'b01, 3, 0, 32'h5555, '0, 2'b10, 0, 3);
        idle(1);
        drive(2'b01, 0, 0, 32'hDEADBEEF, '0, 2'b00, 0, 0);
        drive(2'b00, 0, 0, '0, '0, 2'b11, 0, 0);
        idle(1);
        drive(2'b01, 4, 0, 32'h1234, '0, 2'b00, 0, 0);
        drive(2'b00, 0, 0, '0, '0, 2'b01, 4, 0);
        drive(2'b01, 4, 0, 32'h9, '0, 2'b00, 9, 0);
        idle(3);
        drive(2'b00, 0, 0, '0, '0, 2'b01, 4, 0);
        repeat (400) begin
            int lim;
            lim = ($urandom_range(0, 3) == 0) ? 3 : NREGS - 1;
            drive(2'($urandom), $urandom_range(0, lim), $urandom_range(0, lim), $urandom, $urandom,
                  2'($urandom), $urandom_range(0, lim), $urandom_range(0, lim));
        end
        idle(1);
        for (int i = 0; i < 5 && sbq.size() != 0; i++) @(negedge clk);
        #1;
        chk("sb_drain", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
